sdram_pass_arbiter: RTL and testbench

Shares one sdram full-pass engine (start/rnw/done/ready, 16-bit data) between two requesters, for example two tester FSMs or a tester plus a scrub engine. It owns the sdram reset and init sequencing. It grants whole passes round-robin, routes the per-word ready, wdat and rdat to the owner, and returns a done pulse per pass. It sits between the requester FSMs and the sdram controller.

---
 rtl/sdram_pass_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_sdram_pass_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pass_arbiter.sv
// sdram_pass_arbiter
// Shares one sdram full-pass engine between two requesters. The arbiter
// owns the sdram reset/init sequence, grants whole passes round-robin,
// routes ready/wdat/rdat to the current owner and returns one done pulse
// per pass.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_start/rnw/wdat        pass request, direction, write data (N=0,1)
//   reqN_busy/ready/done       pending-or-granted, per-word strobe, end of pass
//   rdat                       controller read data, passed straight through
//   grant                      one-hot owner (00 = none)
//   timeout                    sticky watchdog flag (0 unless watchdog built)
//   mem_*                      sdram controller interface
//
// Optional build macro: PASS_ARB_WATCHDOG_EN
//   Adds a per-pass cycle counter. A pass with no mem_done after WD_CYCLES
//   cycles in WAIT is ended with a done pulse, sets timeout and sends the
//   arbiter back through INIT so the sdram is re-reset.
module sdram_pass_arbiter #(
    parameter int DW         = 16,
    parameter int RST_CYCLES = 16,
    parameter int WD_CYCLES  = 2**26
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_start,
    input  logic          req0_rnw,
    input  logic [DW-1:0] req0_wdat,
    output logic          req0_busy,
    output logic          req0_ready,
    output logic          req0_done,
    input  logic          req1_start,
    input  logic          req1_rnw,
    input  logic [DW-1:0] req1_wdat,
    output logic          req1_busy,
    output logic          req1_ready,
    output logic          req1_done,
    output logic [DW-1:0] rdat,
    output logic [1:0]    grant,
    output logic          timeout,
    output logic          mem_rst_n,
    output logic          mem_start,
    output logic          mem_rnw,
    output logic [DW-1:0] mem_wdat,
    input  logic          mem_done,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdat
);

    typedef enum logic [2:0] {
        S_INIT,
        S_INITW,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE,
        S_WDREL
    } state_t;

    localparam int             RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

    state_t         state_q, state_d;
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic [1:0]     pending_q, pending_d;
    logic [1:0]     rnw_q, rnw_d;
    logic [1:0]     grant_q, grant_d;
    logic           last_q, last_d;      // index of the previous owner
    logic [1:0]     done_q, done_d;
    logic           wd_expire;           // WAIT has run out of cycles this clock

`ifdef PASS_ARB_WATCHDOG_EN
    localparam int             WCW     = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
    localparam logic [WCW-1:0] WD_LAST = WCW'(WD_CYCLES - 1);

    logic [WCW-1:0] wd_cnt_q, wd_cnt_d;
    logic           timeout_q, timeout_d;

    always_comb begin
        // Counts WAIT cycles; any other state holds it at 0 so each pass
        // starts counting from the first WAIT cycle.
        wd_cnt_d  = (state_q == S_WAIT) ? wd_cnt_q + 1'b1 : '0;
        wd_expire = (state_q == S_WAIT) && !mem_done && (wd_cnt_q == WD_LAST);
        timeout_d = timeout_q | wd_expire;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        pending_d = pending_q;
        rnw_d     = rnw_q;
        grant_d   = grant_q;
        last_d    = last_q;
        done_d    = 2'b00;
        mem_start = 1'b0;
        mem_rnw   = 1'b0;

        // Requests are latched in every state; a start while already
        // pending is dropped and keeps the originally stored direction.
        if (req0_start && !pending_q[0]) begin
            pending_d[0] = 1'b1;
            rnw_d[0]     = req0_rnw;
        end
        if (req1_start && !pending_q[1]) begin
            pending_d[1] = 1'b1;
            rnw_d[1]     = req1_rnw;
        end

        case (state_q)
            S_INIT: begin
                if (rst_cnt_q == RST_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = S_INITW;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_INITW: begin
                if (mem_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                // Arbitration uses registered pending only, so a start in
                // this same cycle competes from the next cycle on.
                if (pending_q != 2'b00) begin
                    if (pending_q == 2'b11) grant_d = last_q ? 2'b01 : 2'b10;
                    else                    grant_d = pending_q;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_start = 1'b1;
                mem_rnw   = grant_q[1] ? rnw_q[1] : rnw_q[0];
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (mem_done)       state_d = S_RELEASE;
                else if (wd_expire) state_d = S_WDREL;
            end
            S_RELEASE, S_WDREL: begin
                // Owner's pending bit is set, so no new start can have
                // touched it this cycle; clearing it here is safe.
                pending_d = pending_d & ~grant_q;
                last_d    = grant_q[1];
                done_d    = grant_q;
                grant_d   = 2'b00;
                state_d   = (state_q == S_WDREL) ? S_INIT : S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            rst_cnt_q <= '0;
            pending_q <= 2'b00;
            rnw_q     <= 2'b00;
            grant_q   <= 2'b00;
            last_q    <= 1'b1;
            done_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            pending_q <= pending_d;
            rnw_q     <= rnw_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

    assign mem_rst_n  = (state_q != S_INIT);
    assign grant      = grant_q;
    assign req0_busy  = pending_q[0];
    assign req1_busy  = pending_q[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    // Word strobes only reach the owner while its pass is in flight.
    assign req0_ready = mem_ready & grant_q[0] & (state_q == S_WAIT);
    assign req1_ready = mem_ready & grant_q[1] & (state_q == S_WAIT);
    assign mem_wdat   = grant_q[0] ? req0_wdat :
                        grant_q[1] ? req1_wdat : '0;
    assign rdat       = mem_rdat;

endmodule

// File: tb/tb_sdram_pass_arbiter.sv
module tb_sdram_pass_arbiter;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_start = 1'b0, req0_rnw = 1'b0;
    logic [DW-1:0] req0_wdat = '0;
    logic          req0_busy, req0_ready, req0_done;
    logic          req1_start = 1'b0, req1_rnw = 1'b0;
    logic [DW-1:0] req1_wdat = '0;
    logic          req1_busy, req1_ready, req1_done;
    logic [DW-1:0] rdat;
    logic [1:0]    grant;
    logic          timeout;
    logic          mem_rst_n, mem_start, mem_rnw;
    logic [DW-1:0] mem_wdat;
    logic          mem_done = 1'b0, mem_ready = 1'b0;
    logic [DW-1:0] mem_rdat = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdram_pass_arbiter #(.DW(DW), .RST_CYCLES(16), .WD_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_start(req0_start), .req0_rnw(req0_rnw), .req0_wdat(req0_wdat),
        .req0_busy(req0_busy), .req0_ready(req0_ready), .req0_done(req0_done),
        .req1_start(req1_start), .req1_rnw(req1_rnw), .req1_wdat(req1_wdat),
        .req1_busy(req1_busy), .req1_ready(req1_ready), .req1_done(req1_done),
        .rdat(rdat), .grant(grant), .timeout(timeout),
        .mem_rst_n(mem_rst_n), .mem_start(mem_start), .mem_rnw(mem_rnw),
        .mem_wdat(mem_wdat), .mem_done(mem_done), .mem_ready(mem_ready),
        .mem_rdat(mem_rdat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Waits (bounded) for the ISSUE cycle, then checks owner and direction.
    task automatic wait_start(input logic [1:0] g, input logic r);
        int i;
        i = 0;
        while (mem_start !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("mem_start", {31'd0, mem_start}, 32'd1);
        chk("grant", {30'd0, grant}, {30'd0, g});
        chk("mem_rnw", {31'd0, mem_rnw}, {31'd0, r});
    endtask

    // Called in the ISSUE cycle; ends the pass and checks the done pulse.
    task automatic finish_pass(input logic [1:0] g);
        @(negedge clk);
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        chk("done_early", {30'd0, req1_done, req0_done}, 32'd0);
        @(negedge clk);
        chk("done", {30'd0, req1_done, req0_done}, {30'd0, g});
        chk("grant_rel", {30'd0, grant}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int cnt;
        logic saw;
        logic [1:0] g;
        int r0, r1;

        // ---- reset state ----
        req0_wdat = 16'hA5A5;
        req1_wdat = 16'h5A5A;
        mem_rdat  = 16'hBEEF;
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_memrst", {31'd0, mem_rst_n}, 32'd0);
        chk("rst_out", {26'd0, req0_busy, req1_busy, req0_done, req1_done, mem_start, timeout}, 32'd0);
        chk("rst_wdat", {16'd0, mem_wdat}, 32'd0);
        chk("rdat_pass", {16'd0, rdat}, 32'h0000BEEF);

        // ---- INIT length, request held during INIT ----
        rst_n = 1'b1;
        cnt = 0;
        saw = 1'b0;
        while (mem_rst_n !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
            req0_rnw   = 1'b0;
            req0_start = (cnt == 2);
        end
        req0_start = 1'b0;
        chk("init_len", cnt, 32'd16);
        chk("init_busy", {31'd0, req0_busy}, 32'd1);
        repeat (2) @(negedge clk);
        chk("initw_hold", {29'd0, mem_start, grant}, 32'd0);
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        chk("idle_cyc1", {31'd0, mem_start}, 32'd0);
        @(negedge clk);
        chk("idle_cyc2", {31'd0, mem_start}, 32'd1);
        chk("first_grant", {30'd0, grant}, 32'd1);
        chk("first_rnw", {31'd0, mem_rnw}, 32'd0);

        // ---- single write pass; mem_done during ISSUE is ignored ----
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        chk("issue_done_ign", {29'd0, grant, req0_done}, 32'd2);
        chk("wdat_route", {16'd0, mem_wdat}, 32'h0000A5A5);
        r0 = 0;
        r1 = 0;
        for (int i = 0; i < 8; i++) begin
            mem_ready = 1'b1;
            #1;
            if (req0_ready === 1'b1) r0++;
            if (req1_ready === 1'b1) r1++;
            @(negedge clk);
            mem_ready = 1'b0;
            @(negedge clk);
        end
        chk("ready0_cnt", r0, 32'd8);
        chk("ready1_cnt", r1, 32'd0);
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        chk("done_early", {30'd0, req1_done, req0_done}, 32'd0);
        @(negedge clk);
        chk("wr_done", {30'd0, req1_done, req0_done}, 32'd1);
        chk("wr_grant_rel", {30'd0, grant, req0_busy}, 32'd0);
        chk("wdat_nogrant", {16'd0, mem_wdat}, 32'd0);

        // ---- duplicate start: first rnw kept, one pass only ----
        req1_rnw   = 1'b1;
        req1_start = 1'b1;
        @(negedge clk);
        req1_rnw   = 1'b0;
        @(negedge clk);
        req1_start = 1'b0;
        wait_start(2'b10, 1'b1);
        finish_pass(2'b10);
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (mem_start !== 1'b0) saw = 1'b1;
        end
        chk("dup_one_pass", {30'd0, saw, req1_busy}, 32'd0);

        // ---- contention and alternation 0,1,0,1 ----
        req0_rnw   = 1'b1;
        req1_rnw   = 1'b0;
        req0_start = 1'b1;
        req1_start = 1'b1;
        @(negedge clk);
        req0_start = 1'b0;
        req1_start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            g = (p % 2 == 0) ? 2'b01 : 2'b10;
            wait_start(g, g[0]);
            finish_pass(g);
            if (p < 2) begin
                req0_start = g[0];
                req1_start = g[1];
                @(negedge clk);
                req0_start = 1'b0;
                req1_start = 1'b0;
            end
        end

        // ---- reset during WAIT ----
        req0_rnw   = 1'b0;
        req0_start = 1'b1;
        @(negedge clk);
        req0_start = 1'b0;
        wait_start(2'b01, 1'b0);
        @(negedge clk);
        chk("wait_grant", {30'd0, grant}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst", {27'd0, grant, req0_done, req0_busy, mem_rst_n}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        saw = 1'b0;
        while (mem_rst_n !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (req0_done !== 1'b0 || req1_done !== 1'b0) saw = 1'b1;
        end
        chk("reinit_len", cnt, 32'd16);
        chk("reinit_nodone", {31'd0, saw}, 32'd0);
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;

        // ---- stalled pass ----
        req0_start = 1'b1;
        @(negedge clk);
        req0_start = 1'b0;
        wait_start(2'b01, 1'b0);
`ifdef PASS_ARB_WATCHDOG_EN
        cnt = 0;
        while (req0_done !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk("wd_latency", cnt, 32'd102);
        chk("wd_timeout", {31'd0, timeout}, 32'd1);
        chk("wd_state", {29'd0, grant, mem_rst_n}, 32'd0);
        chk("wd_busy", {31'd0, req0_busy}, 32'd0);
`else
        saw = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (req0_done !== 1'b0) saw = 1'b1;
        end
        chk("nowd_grant", {30'd0, grant}, 32'd1);
        chk("nowd_flags", {30'd0, saw, timeout}, 32'd0);
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        @(negedge clk);
        chk("nowd_done", {30'd0, req1_done, req0_done}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
